// File: rtl/switch_debounce_toggle.sv
// Per-channel switch conditioner: 2-FF synchronizer, stable-count debounce,
// registered press/release pulses and a press-toggled LED register.
module switch_debounce_toggle #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_LED
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_SW-1:0] sync_s1;
    logic [NUM_SW-1:0] sync_s2;
    logic [CNT_W-1:0]  stable_cnt [NUM_SW];

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            o_Switch  <= '0;
            o_Press   <= '0;
            o_Release <= '0;
            o_LED     <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                stable_cnt[i] <= '0;
            end
        end else begin
            sync_s1   <= i_Switch;
            sync_s2   <= sync_s1;
            o_Press   <= '0;
            o_Release <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync_s2[i] == o_Switch[i]) begin
                    // any return to the accepted level restarts qualification
                    stable_cnt[i] <= '0;
                end else if (stable_cnt[i] != CNT_LAST) begin
                    stable_cnt[i] <= stable_cnt[i] + CNT_ONE;
                end else begin
                    stable_cnt[i] <= '0;
                    o_Switch[i]   <= sync_s2[i];
                    if (sync_s2[i]) begin
                        o_Press[i] <= 1'b1;
                        o_LED[i]   <= ~o_LED[i];
                    end else begin
                        o_Release[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Directed plus randomized checks of switch_debounce_toggle against a
// window-based reference model (accept after LIMIT consecutive differing samples).
module tb_switch_debounce_toggle;

    localparam int NSW   = 4;
    localparam int LIMIT = 4;

    logic           clk = 1'b0;
    logic           i_Reset;
    logic [NSW-1:0] i_Switch;
    logic [NSW-1:0] o_Switch, o_Press, o_Release, o_LED;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [NSW-1:0] m_s1, m_s2, m_sw, m_pr, m_rl, m_led;
    logic [NSW-1:0] hq [$];

    switch_debounce_toggle #(.NUM_SW(NSW), .DEBOUNCE_LIMIT(LIMIT)) dut (
        .i_Clk    (clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_LED    (o_LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NSW-1:0] obs, input logic [NSW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [NSW-1:0] sw, input logic rst);
        logic all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0; m_pr = '0; m_rl = '0; m_led = '0;
            hq.delete();
        end else begin
            hq.push_back(m_s2);
            if (hq.size() > LIMIT) void'(hq.pop_front());
            m_pr = '0;
            m_rl = '0;
            for (int n = 0; n < NSW; n++) begin
                if (hq.size() == LIMIT) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < LIMIT; k++)
                        if (hq[k][n] == m_sw[n]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (!m_sw[n]) begin
                            m_pr[n]  = 1'b1;
                            m_led[n] = ~m_led[n];
                        end else begin
                            m_rl[n] = 1'b1;
                        end
                        m_sw[n] = ~m_sw[n];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    task automatic step(input logic [NSW-1:0] sw, input logic rst);
        i_Switch = sw;
        i_Reset  = rst;
        @(posedge clk);
        model_edge(sw, rst);
        #1;
        check("model_switch",  o_Switch,  m_sw);
        check("model_press",   o_Press,   m_pr);
        check("model_release", o_Release, m_rl);
        check("model_led",     o_LED,     m_led);
        check("press_release_overlap", o_Press & o_Release, '0);
    endtask

    initial begin
        logic [NSW-1:0] rsw;
        i_Switch = '0;
        i_Reset  = 1'b1;

        // 1: reset with all switches held, then requalify
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b1);
            check("t1_rst_switch", o_Switch, 4'h0);
            check("t1_rst_led", o_LED, 4'h0);
        end
        for (int i = 0; i < 5; i++) step(4'hF, 1'b0);
        check("t1_pre_switch", o_Switch, 4'h0);
        step(4'hF, 1'b0);
        check("t1_switch", o_Switch, 4'hF);
        check("t1_press", o_Press, 4'hF);
        check("t1_led", o_LED, 4'hF);
        step(4'hF, 1'b0);
        check("t1_press_clear", o_Press, 4'h0);

        // 2: clean press of switch 1
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
        check("t2_pre_switch", o_Switch, 4'b0000);
        step(4'b0001, 1'b0);
        check("t2_switch", o_Switch, 4'b0001);
        check("t2_press", o_Press, 4'b0001);
        check("t2_led", o_LED, 4'b0001);
        step(4'b0001, 1'b0);
        check("t2_press_clear", o_Press, 4'b0000);

        // 3: bouncing switch 2, then held
        for (int i = 0; i < 8; i++) step({2'b00, ((i % 4) < 2), 1'b1}, 1'b0);
        check("t3_bounce_switch", o_Switch, 4'b0001);
        for (int i = 0; i < 5; i++) step(4'b0011, 1'b0);
        check("t3_pre_switch", o_Switch, 4'b0001);
        step(4'b0011, 1'b0);
        check("t3_press", o_Press, 4'b0010);
        check("t3_led", o_LED, 4'b0011);

        // 4: press, hold, release, press again on switch 3
        for (int i = 0; i < 6; i++) step(4'b0111, 1'b0);
        check("t4_press", o_Press, 4'b0100);
        check("t4_led_on", o_LED, 4'b0111);
        for (int i = 0; i < 4; i++) step(4'b0111, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0011, 1'b0);
        check("t4_pre_release", o_Switch, 4'b0111);
        step(4'b0011, 1'b0);
        check("t4_release", o_Release, 4'b0100);
        check("t4_led_hold", o_LED, 4'b0111);
        for (int i = 0; i < 6; i++) step(4'b0111, 1'b0);
        check("t4_led_off", o_LED, 4'b0011);

        // 5: reset in the middle of qualifying switch 4
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
        check("t5_no_early_press", o_Press, 4'b0000);
        step(4'b1011, 1'b1);
        check("t5_rst_switch", o_Switch, 4'b0000);
        for (int i = 0; i < 5; i++) step(4'b1011, 1'b0);
        check("t5_pre_switch", o_Switch, 4'b0000);
        step(4'b1011, 1'b0);
        check("t5_press", o_Press, 4'b1011);
        check("t5_led", o_LED, 4'b1011);

        // 6: simultaneous press on switches 1 and 4
        step(4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b1001, 1'b0);
        check("t6_press", o_Press, 4'b1001);
        check("t6_led", o_LED, 4'b1001);

        // randomized slow-changing inputs with occasional reset
        rsw = 4'b1001;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) rsw[$urandom_range(NSW-1)] ^= 1'b1;
            step(rsw, ($urandom_range(199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
